sdram_arbit: RTL and testbench
==============================

# sdram_arbit

Parametrised SDRAM command-bus arbiter between the SDRAM controller sub-blocks (sdram_init, auto-refresh, sdram_write, sdram_read) and the SDRAM pins. It holds the bus for sdram_init until initialisation completes. After that it grants exclusive bus ownership to one requester at a time: refresh first, then write or read, in fixed-priority or round-robin order. Grants pass through an idle NOP state, and an optional watchdog recovers from a hung owner.

## Interface
- DATA_W, 16, SDRAM DQ width
- ADDR_W, 13, SDRAM address width
- BANK_W, 2, bank address width
- RR_MODE, 0, 0 = fixed priority aref>wr>rd; 1 = aref first, then wr/rd round-robin
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with SDRAM_ARBIT_TIMEOUT_EN)

Ports:
- clk_100M  in  1  clock
- locked_rst_n  in  1  reset, asynchronous, active-low
- init_end  in  1  init done (held high)
- init_cmd / init_bank_addr / init_addr  in  4 / BANK_W / ADDR_W  init command bus
- aref_req, aref_end  in  1  refresh request (level), refresh done (1-cycle pulse)
- aref_cmd / aref_bank_addr / aref_addr  in  4 / BANK_W / ADDR_W  refresh command bus
- wr_req, wr_end  in  1  write request (level), write done (pulse)
- wr_cmd / wr_bank_addr / wr_sdram_addr  in  4 / BANK_W / ADDR_W  write command bus
- wr_sdram_data  in  DATA_W  write data
- wr_sdram_en  in  1  write data drive enable
- rd_req, rd_end  in  1  read request (level), read done (pulse)
- rd_cmd / rd_bank_addr / rd_sdram_addr  in  4 / BANK_W / ADDR_W  read command bus
- aref_en, wr_en, rd_en  out  1  grants
- sdram_cmd / sdram_bank_addr / sdram_addr  out  4 / BANK_W / ADDR_W  to device
- sdram_dq  inout  DATA_W  device data bus
- rd_dq  out  DATA_W  sdram_dq forwarded to the read block
- timeout_err  out  1  sticky watchdog error

## Operation
- State machine states: INIT, ARBIT, AREF, WRITE, READ. Reset state is INIT.
- INIT transitions to ARBIT on the first cycle with init_end=1.
- ARBIT makes the grant decision:
  - aref_req transitions to AREF.
  - Otherwise, with RR_MODE=0: wr_req transitions to WRITE, else rd_req transitions to READ.
  - With RR_MODE=1 and both wr_req and rd_req set: grant the one opposite last_grant. last_grant resets to READ, so write goes first.
- AREF, WRITE and READ transition to ARBIT on their respective *_end pulse.
- No preemption: a request raised during another grant waits for that grant to end.
- Requesters hold *_req until they see *_en; a request dropped before the grant is ignored.
- Grant outputs are decoded from the state register: aref_en=(AREF), wr_en=(WRITE), rd_en=(READ).
- Bus mux by state:
  - INIT selects init_*, AREF selects aref_*, WRITE selects wr_*, READ selects rd_*.
  - ARBIT drives NOP: cmd 4'b0111, bank all-ones, addr all-ones.
- sdram_dq is driven with wr_sdram_data only when state==WRITE && wr_sdram_en; otherwise it is high-Z.
- rd_dq = sdram_dq, combinational.

## Timing
- Reset values:
  - state INIT.
  - aref_en, wr_en, rd_en = 0.
  - timeout_err = 0.
  - sdram_* outputs follow init_* (asynchronous reset forces INIT).
  - sdram_dq is high-Z.
- Grant latency: request sampled in ARBIT at edge N; *_en high from edge N+1.
- Release: *_end at edge M; *_en low and ARBIT from edge M+1; the next grant is at M+2 at earliest. There is always at least one NOP cycle between owners.
- A *_end pulse that does not belong to the current owner is ignored.
- Reset mid-grant: immediate return to INIT; all enables drop asynchronously; dq is released.

## Configuration
- SDRAM_ARBIT_TIMEOUT_EN defined:
  - A counter of width clog2(TIMEOUT_CYC) clears on grant entry and increments every cycle in AREF, WRITE or READ.
  - At TIMEOUT_CYC-1 without the matching *_end, the state is forced to ARBIT and timeout_err is set.
  - timeout_err stays set until reset.
  - last_grant is updated as on a normal end.
- Not defined: no counter is built, and timeout_err is tied 0.

## Structure
- Package sdram_pkg holds:
  - command constants: CMD_NOP 4'b0111 and the other SDRAM command encodings shared with the init, write and read blocks;
  - the state enum typedef;
  - the RR_MODE constants.
- One sub-module, sdram_arbit_grant: combinational next-grant selection from aref_req, wr_req, rd_req, last_grant and RR_MODE.

## Test plan
- Reset with init_end=0 -> sdram_cmd follows init_cmd and all enables are 0. Pulse init_end -> next cycle state ARBIT and sdram_cmd=4'b0111, addr=13'h1FFF, bank=2'b11.
- RR_MODE=0, wr_req and rd_req both high at edge N -> wr_en=1 at N+1. wr_end at edge M -> wr_en=0 at M+1 and rd_en=1 at M+2.
- RR_MODE=1, wr_req and rd_req held high, each block ends after 20 cycles -> grant sequence W,R,W,R, each separated by exactly one NOP cycle.
- aref_req, wr_req and rd_req raised together in ARBIT -> aref_en first. aref_req raised during WRITE -> no preemption; AREF granted at M+2 after wr_end.
- SDRAM_ARBIT_TIMEOUT_EN with TIMEOUT_CYC=64, rd_end never pulsed -> rd_en drops after 64 cycles in READ, timeout_err=1 and stays 1.
- locked_rst_n asserted mid-WRITE while wr_sdram_en=1 -> wr_en=0 and sdram_dq=Z immediately, state INIT.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, arbiter state type and round-robin mode constants
// used by the arbiter and the init / write / read controller blocks.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_BST  = 4'b0110;
  localparam logic [3:0] CMD_NOP  = 4'b0111;

  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sdram_arbit_grant.sv
// Next-owner selection made in the ARBIT state. Refresh always wins; write/read
// contention resolves by fixed priority or by alternating against last_grant.
module sdram_arbit_grant
  import sdram_pkg::*;
#(
  parameter int RR_MODE = RR_FIXED
) (
  input  logic       aref_req,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       last_grant,  // 1 = last data owner was READ
  output arb_state_t nxt
);

  always_comb begin
    nxt = ST_ARBIT;
    if (aref_req)
      nxt = ST_AREF;
    else if (wr_req && rd_req)
      nxt = (RR_MODE == RR_ROUND && !last_grant) ? ST_READ : ST_WRITE;
    else if (wr_req)
      nxt = ST_WRITE;
    else if (rd_req)
      nxt = ST_READ;
  end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: init owns the bus until init_end, then one owner at a
// time with a NOP cycle between owners. Watchdog built with SDRAM_ARBIT_TIMEOUT_EN.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 13,
  parameter int BANK_W      = 2,
  parameter int RR_MODE     = RR_FIXED,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_100M,
  input  logic              locked_rst_n,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BANK_W-1:0] init_bank_addr,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [BANK_W-1:0] aref_bank_addr,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BANK_W-1:0] wr_bank_addr,
  input  logic [ADDR_W-1:0] wr_sdram_addr,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              wr_sdram_en,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BANK_W-1:0] rd_bank_addr,
  input  logic [ADDR_W-1:0] rd_sdram_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [3:0]        sdram_cmd,
  output logic [BANK_W-1:0] sdram_bank_addr,
  output logic [ADDR_W-1:0] sdram_addr,
  inout  wire  [DATA_W-1:0] sdram_dq,
  output logic [DATA_W-1:0] rd_dq,
  output logic              timeout_err
);

  arb_state_t state, nxt_grant;
  logic       last_grant;
  logic       owner, own_end, wd_exp;

  sdram_arbit_grant #(.RR_MODE(RR_MODE)) u_grant (
    .aref_req  (aref_req),
    .wr_req    (wr_req),
    .rd_req    (rd_req),
    .last_grant(last_grant),
    .nxt       (nxt_grant)
  );

  assign owner   = (state == ST_AREF) || (state == ST_WRITE) || (state == ST_READ);
  assign own_end = (state == ST_AREF  && aref_end) ||
                   (state == ST_WRITE && wr_end)   ||
                   (state == ST_READ  && rd_end);

`ifdef SDRAM_ARBIT_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] WD_LIM = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] wd_cnt;

  assign wd_exp = owner && (wd_cnt == WD_LIM);

  // Counter is held at zero outside ownership, so it restarts on every grant entry.
  always_ff @(posedge clk_100M or negedge locked_rst_n)
    if (!locked_rst_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt <= owner ? wd_cnt + 1'b1 : '0;
      if (wd_exp && !own_end) timeout_err <= 1'b1;
    end
`else
  assign wd_exp      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk_100M or negedge locked_rst_n)
    if (!locked_rst_n) begin
      state      <= ST_INIT;
      last_grant <= 1'b1;
    end else begin
      case (state)
        ST_INIT:  if (init_end) state <= ST_ARBIT;
        ST_ARBIT: state <= nxt_grant;
        ST_AREF:  if (aref_end || wd_exp) state <= ST_ARBIT;
        ST_WRITE: if (wr_end || wd_exp) begin
                    state      <= ST_ARBIT;
                    last_grant <= 1'b0;
                  end
        ST_READ:  if (rd_end || wd_exp) begin
                    state      <= ST_ARBIT;
                    last_grant <= 1'b1;
                  end
        default:  state <= ST_INIT;
      endcase
    end

  assign aref_en = (state == ST_AREF);
  assign wr_en   = (state == ST_WRITE);
  assign rd_en   = (state == ST_READ);

  always_comb begin
    sdram_cmd       = CMD_NOP;
    sdram_bank_addr = {BANK_W{1'b1}};
    sdram_addr      = {ADDR_W{1'b1}};
    case (state)
      ST_INIT:  begin sdram_cmd = init_cmd; sdram_bank_addr = init_bank_addr; sdram_addr = init_addr;     end
      ST_AREF:  begin sdram_cmd = aref_cmd; sdram_bank_addr = aref_bank_addr; sdram_addr = aref_addr;     end
      ST_WRITE: begin sdram_cmd = wr_cmd;   sdram_bank_addr = wr_bank_addr;   sdram_addr = wr_sdram_addr; end
      ST_READ:  begin sdram_cmd = rd_cmd;   sdram_bank_addr = rd_bank_addr;   sdram_addr = rd_sdram_addr; end
      default:  ;
    endcase
  end

  assign sdram_dq = (state == ST_WRITE && wr_sdram_en) ? wr_sdram_data : {DATA_W{1'bz}};
  assign rd_dq    = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: fixed-priority (u0) and round-robin (u1) instances
// share stimulus; each scenario checks the instance whose behaviour it targets.
module tb_sdram_arbit;

  logic        clk_100M = 1'b0;
  logic        locked_rst_n;
  logic        init_end;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]  init_bank_addr, aref_bank_addr, wr_bank_addr, rd_bank_addr;
  logic [12:0] init_addr, aref_addr, wr_sdram_addr, rd_sdram_addr;
  logic        aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic [15:0] wr_sdram_data;
  logic        wr_sdram_en;
  logic        tb_oe;
  logic [15:0] tb_dq;

  logic        aref_en_0, wr_en_0, rd_en_0, terr_0;
  logic        aref_en_1, wr_en_1, rd_en_1, terr_1;
  logic [3:0]  cmd_0, cmd_1;
  logic [1:0]  bank_0, bank_1;
  logic [12:0] addr_0, addr_1;
  logic [15:0] rd_dq_0, rd_dq_1;
  tri   [15:0] dq_0, dq_1;

  assign dq_0 = tb_oe ? tb_dq : 16'bz;
  assign dq_1 = tb_oe ? tb_dq : 16'bz;

  always #5 clk_100M = ~clk_100M;

  sdram_arbit #(.RR_MODE(0), .TIMEOUT_CYC(64)) u0 (
    .clk_100M(clk_100M), .locked_rst_n(locked_rst_n), .init_end(init_end),
    .init_cmd(init_cmd), .init_bank_addr(init_bank_addr), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
    .aref_bank_addr(aref_bank_addr), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank_addr(wr_bank_addr),
    .wr_sdram_addr(wr_sdram_addr), .wr_sdram_data(wr_sdram_data), .wr_sdram_en(wr_sdram_en),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank_addr(rd_bank_addr),
    .rd_sdram_addr(rd_sdram_addr),
    .aref_en(aref_en_0), .wr_en(wr_en_0), .rd_en(rd_en_0),
    .sdram_cmd(cmd_0), .sdram_bank_addr(bank_0), .sdram_addr(addr_0),
    .sdram_dq(dq_0), .rd_dq(rd_dq_0), .timeout_err(terr_0));

  sdram_arbit #(.RR_MODE(1), .TIMEOUT_CYC(64)) u1 (
    .clk_100M(clk_100M), .locked_rst_n(locked_rst_n), .init_end(init_end),
    .init_cmd(init_cmd), .init_bank_addr(init_bank_addr), .init_addr(init_addr),
    .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd),
    .aref_bank_addr(aref_bank_addr), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank_addr(wr_bank_addr),
    .wr_sdram_addr(wr_sdram_addr), .wr_sdram_data(wr_sdram_data), .wr_sdram_en(wr_sdram_en),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank_addr(rd_bank_addr),
    .rd_sdram_addr(rd_sdram_addr),
    .aref_en(aref_en_1), .wr_en(wr_en_1), .rd_en(rd_en_1),
    .sdram_cmd(cmd_1), .sdram_bank_addr(bank_1), .sdram_addr(addr_1),
    .sdram_dq(dq_1), .rd_dq(rd_dq_1), .timeout_err(terr_1));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_100M);
    #1;
  endtask

  initial begin
    locked_rst_n = 1'b0; init_end = 1'b0;
    init_cmd = 4'b0010; init_bank_addr = 2'b00; init_addr = 13'h0400;
    aref_cmd = 4'b0001; aref_bank_addr = 2'b10; aref_addr = 13'h0055;
    wr_cmd = 4'b0100; wr_bank_addr = 2'b01; wr_sdram_addr = 13'h0123;
    rd_cmd = 4'b0101; rd_bank_addr = 2'b10; rd_sdram_addr = 13'h0456;
    aref_req = 0; aref_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
    wr_sdram_data = 16'hA5A5; wr_sdram_en = 1'b0; tb_oe = 1'b0; tb_dq = 16'h0;

    // Reset and init hand-off
    #12;
    chk("rst_cmd", 32'(cmd_0), 32'h2);
    chk("rst_addr", 32'(addr_0), 32'h400);
    chk("rst_en", 32'({aref_en_0, wr_en_0, rd_en_0, aref_en_1, wr_en_1, rd_en_1}), 32'h0);
    chk("rst_terr", 32'({terr_0, terr_1}), 32'h0);
    locked_rst_n = 1'b1;
    tick(2);
    chk("init_hold_cmd", 32'(cmd_0), 32'h2);
    init_end = 1'b1;
    tick(1);
    chk("arbit_nop_cmd", 32'(cmd_0), 32'h7);
    chk("arbit_nop_addr", 32'(addr_0), 32'h1FFF);
    chk("arbit_nop_bank", 32'(bank_0), 32'h3);

    // Fixed priority: write before read, one NOP between
    wr_req = 1; rd_req = 1;
    tick(1);
    chk("fp_wr_grant", 32'({wr_en_0, rd_en_0}), 32'h2);
    chk("fp_wr_bus", 32'({cmd_0, bank_0, addr_0}), 32'({4'b0100, 2'b01, 13'h0123}));
    wr_req = 0; wr_sdram_en = 1;
    #1 chk("fp_wr_dq", 32'(dq_0), 32'hA5A5);
    tick(2);
    wr_end = 1;
    tick(1);
    chk("fp_wr_release", 32'({wr_en_0, rd_en_0}), 32'h0);
    chk("fp_gap_nop", 32'(cmd_0), 32'h7);
    wr_end = 0; wr_sdram_en = 0;
    tick(1);
    chk("fp_rd_grant", 32'({wr_en_0, rd_en_0}), 32'h1);
    chk("fp_rd_bus", 32'({cmd_0, bank_0, addr_0}), 32'({4'b0101, 2'b10, 13'h0456}));
    rd_req = 0; tb_oe = 1; tb_dq = 16'h3C3C;
    #1 chk("fp_rd_dq", 32'(rd_dq_0), 32'h3C3C);
    tb_oe = 0;
    rd_end = 1;
    tick(1);
    rd_end = 0;
    chk("fp_rd_release", 32'(rd_en_0), 32'h0);

    // Refresh priority and no preemption
    aref_req = 1; wr_req = 1; rd_req = 1;
    tick(1);
    chk("aref_first", 32'({aref_en_0, wr_en_0, rd_en_0}), 32'h4);
    chk("aref_bus", 32'({cmd_0, bank_0, addr_0}), 32'({4'b0001, 2'b10, 13'h0055}));
    aref_req = 0;
    tick(2);
    aref_end = 1;
    tick(1);
    aref_end = 0;
    chk("aref_release", 32'(aref_en_0), 32'h0);
    tick(1);
    chk("wr_after_aref", 32'({wr_en_0, wr_en_1}), 32'h3);
    aref_req = 1;
    tick(3);
    chk("no_preempt", 32'({aref_en_0, wr_en_0}), 32'h1);
    wr_req = 0; wr_end = 1;
    tick(1);
    wr_end = 0;
    chk("preempt_gap", 32'({aref_en_0, wr_en_0, rd_en_0}), 32'h0);
    tick(1);
    chk("aref_at_m2", 32'({aref_en_0, rd_en_0, aref_en_1}), 32'h5);
    aref_req = 0; aref_end = 1;
    tick(1);
    aref_end = 0;
    tick(1);
    chk("rd_after_aref", 32'({rd_en_0, rd_en_1}), 32'h3);
    rd_req = 0; rd_end = 1;
    tick(1);
    rd_end = 0;

    // Asynchronous reset in the middle of a driven write
    wr_req = 1;
    tick(1);
    chk("rst_wr_grant", 32'(wr_en_0), 32'h1);
    wr_req = 0; wr_sdram_en = 1;
    #1 chk("rst_wr_dq", 32'(dq_0), 32'hA5A5);
    locked_rst_n = 1'b0;
    #1;
    chk("rst_mid_en", 32'({wr_en_0, wr_en_1}), 32'h0);
    chk("rst_mid_cmd", 32'({cmd_0, addr_0}), 32'({4'b0010, 13'h0400}));
    tb_oe = 1; tb_dq = 16'h5A5A;
    #1 chk("rst_mid_dq_free", 32'(rd_dq_0), 32'h5A5A);
    tb_oe = 0; wr_sdram_en = 0;
    #2 locked_rst_n = 1'b1;
    #1 chk("rst_init_cmd", 32'(cmd_0), 32'h2);
    tick(1);
    chk("rst_back_arbit", 32'(cmd_0), 32'h7);

    // Round robin with both requests held: W,R,W,R with a single NOP between
    wr_req = 1; rd_req = 1;
    for (int i = 0; i < 4; i++) begin
      automatic logic exp_w = (i % 2 == 0);
      tick(1);
      chk($sformatf("rr_grant%0d", i), 32'({wr_en_1, rd_en_1}), exp_w ? 32'h2 : 32'h1);
      chk($sformatf("fp_hold%0d", i), 32'(wr_en_0), 32'h1);
      tick(19);
      if (exp_w) wr_end = 1; else rd_end = 1;
      tick(1);
      wr_end = 0; rd_end = 0;
      chk($sformatf("rr_nop%0d", i), 32'({wr_en_1, rd_en_1, cmd_1}), 32'h7);
      chk($sformatf("fp_foreign_end%0d", i), 32'(wr_en_0), exp_w ? 32'h0 : 32'h1);
    end
    wr_req = 0; rd_req = 0; wr_end = 1;
    tick(1);
    wr_end = 0;
    tick(1);
    chk("idle_both", 32'({wr_en_0, rd_en_0, wr_en_1, rd_en_1}), 32'h0);

    // Hung read owner
    rd_req = 1;
    tick(1);
    chk("wd_rd_grant", 32'({rd_en_0, rd_en_1}), 32'h3);
    rd_req = 0;
    tick(63);
    chk("wd_before_lim", 32'({rd_en_0, terr_0}), 32'h2);
    tick(1);
`ifdef SDRAM_ARBIT_TIMEOUT_EN
    chk("wd_expire", 32'({rd_en_0, terr_0, rd_en_1, terr_1}), 32'h5);
    tick(5);
    chk("wd_sticky", 32'({terr_0, terr_1}), 32'h3);
`else
    chk("wd_absent", 32'({rd_en_0, terr_0, rd_en_1, terr_1}), 32'hA);
    rd_end = 1;
    tick(1);
    rd_end = 0;
    chk("wd_absent_end", 32'({rd_en_0, terr_0}), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
